// File: rtl/spike_packet_receiver.sv
// spike_packet_receiver
//   Receive side of the neuromorphic NoC interface. Incoming spike packets
//   {src_addr, dst_addr} are buffered in a small FIFO. Each packet's dst_addr
//   is matched against the local neuron address table. On a hit, the synapse
//   table is scanned once, and every entry whose source and target neuron
//   match emits its weight, tagged with the local neuron index.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   clear_i                 synchronous timestep clear: flush FIFO, abort scan
//   packet_i/valid/ready    packet input handshake (transfer on valid && ready)
//   cfg_neuron_*            neuron address table write port
//   cfg_syn_*               synapse table write port {valid, src, dst_idx, weight}
//   weight_valid_o          one-cycle strobe with weight_out_o / neuron_index_o
//   busy_o                  FSM not idle or FIFO not empty
//   drop_count_o            packets with no local destination (saturating)
//
// state  | meaning
// IDLE   | wait for FIFO non-empty, pop head into work register
// MATCH  | compare work dst_addr against all neuron addresses
// SCAN   | walk synapse table one entry per cycle, strobe on hit
module spike_packet_receiver #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYN_DEPTH   = 16,
    parameter int WEIGHT_W    = 16,
    parameter int NIDX_W      = $clog2(NUM_NEURONS),
    parameter int SIDX_W      = $clog2(SYN_DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic [2*ADDR_W-1:0]            packet_i,
    input  logic                           packet_valid_i,
    output logic                           packet_ready_o,
    input  logic                           cfg_neuron_we_i,
    input  logic [NIDX_W-1:0]              cfg_neuron_idx_i,
    input  logic [ADDR_W-1:0]              cfg_neuron_addr_i,
    input  logic                           cfg_syn_we_i,
    input  logic [SIDX_W-1:0]              cfg_syn_idx_i,
    input  logic [ADDR_W+NIDX_W+WEIGHT_W:0] cfg_syn_entry_i,
    output logic                           weight_valid_o,
    output logic [WEIGHT_W-1:0]            weight_out_o,
    output logic [NIDX_W-1:0]              neuron_index_o,
    output logic                           busy_o,
    output logic [7:0]                     drop_count_o
);

    localparam int PKT_W = 2 * ADDR_W;
    localparam int SYN_W = ADDR_W + NIDX_W + WEIGHT_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MATCH = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;

    logic [PKT_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   naddr_q [NUM_NEURONS];
    logic [SYN_W-1:0]    syn_q [SYN_DEPTH];

    logic [1:0]          state_q, state_d;
    logic [PKT_W-1:0]    work_q, work_d;
    logic [NIDX_W-1:0]   k_q, k_d;
    logic [SIDX_W-1:0]   scan_q, scan_d;
    logic [7:0]          drop_q, drop_d;
    logic                wv_q, wv_d;
    logic [WEIGHT_W-1:0] w_q, w_d;
    logic [NIDX_W-1:0]   idx_q, idx_d;

    logic fifo_full, fifo_empty, push, pop;
    logic hit;
    logic [NIDX_W-1:0] hit_idx;
    logic [SYN_W-1:0]  syn_cur;
    logic              syn_hit;

    assign fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty     = (count_q == '0);
    assign packet_ready_o = !fifo_full && !clear_i;
    assign push           = packet_valid_i && packet_ready_o;
    assign pop            = (state_q == ST_IDLE) && !fifo_empty && !clear_i;

    // Descending walk so the lowest matching neuron index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (naddr_q[i] == work_q[ADDR_W-1:0]) begin
                hit     = 1'b1;
                hit_idx = NIDX_W'(i);
            end
        end
    end

    assign syn_cur = syn_q[scan_q];
    assign syn_hit = syn_cur[SYN_W-1]
                  && (syn_cur[SYN_W-2 -: ADDR_W] == work_q[PKT_W-1 -: ADDR_W])
                  && (syn_cur[WEIGHT_W +: NIDX_W] == k_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        k_d     = k_q;
        scan_d  = scan_q;
        drop_d  = drop_q;
        wv_d    = 1'b0;
        w_d     = w_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    work_d  = fifo_q[rd_ptr_q];
                    state_d = ST_MATCH;
                end
            end
            ST_MATCH: begin
                if (hit) begin
                    k_d     = hit_idx;
                    scan_d  = '0;
                    state_d = ST_SCAN;
                end else begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (syn_hit) begin
                    wv_d  = 1'b1;
                    w_d   = syn_cur[WEIGHT_W-1:0];
                    idx_d = k_q;
                end
                if (scan_q == SIDX_W'(SYN_DEPTH - 1)) state_d = ST_IDLE;
                else                                   scan_d  = scan_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // A timestep clear abandons the current packet without counting it.
        if (clear_i) begin
            state_d = ST_IDLE;
            wv_d    = 1'b0;
            w_d     = w_q;
            idx_d   = idx_q;
            drop_d  = drop_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= packet_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // 'hFFF never matches a real destination, so reset leaves every neuron unreachable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) naddr_q[i] <= '1;
            for (int i = 0; i < SYN_DEPTH; i++)   syn_q[i]   <= '0;
        end else begin
            if (cfg_neuron_we_i && (32'(cfg_neuron_idx_i) < NUM_NEURONS))
                naddr_q[cfg_neuron_idx_i] <= cfg_neuron_addr_i;
            if (cfg_syn_we_i)
                syn_q[cfg_syn_idx_i] <= cfg_syn_entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            k_q     <= '0;
            scan_q  <= '0;
            drop_q  <= '0;
            wv_q    <= 1'b0;
            w_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            k_q     <= k_d;
            scan_q  <= scan_d;
            drop_q  <= drop_d;
            wv_q    <= wv_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
        end
    end

    assign weight_valid_o = wv_q;
    assign weight_out_o   = w_q;
    assign neuron_index_o = idx_q;
    assign drop_count_o   = drop_q;
    assign busy_o         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spike_packet_receiver.sv
module tb_spike_packet_receiver;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [23:0] packet_i;
    logic        packet_valid_i;
    logic        packet_ready_o;
    logic        cfg_neuron_we_i;
    logic [3:0]  cfg_neuron_idx_i;
    logic [11:0] cfg_neuron_addr_i;
    logic        cfg_syn_we_i;
    logic [3:0]  cfg_syn_idx_i;
    logic [32:0] cfg_syn_entry_i;
    logic        weight_valid_o;
    logic [15:0] weight_out_o;
    logic [3:0]  neuron_index_o;
    logic        busy_o;
    logic [7:0]  drop_count_o;

    spike_packet_receiver dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .packet_i(packet_i), .packet_valid_i(packet_valid_i), .packet_ready_o(packet_ready_o),
        .cfg_neuron_we_i(cfg_neuron_we_i), .cfg_neuron_idx_i(cfg_neuron_idx_i),
        .cfg_neuron_addr_i(cfg_neuron_addr_i),
        .cfg_syn_we_i(cfg_syn_we_i), .cfg_syn_idx_i(cfg_syn_idx_i), .cfg_syn_entry_i(cfg_syn_entry_i),
        .weight_valid_o(weight_valid_o), .weight_out_o(weight_out_o),
        .neuron_index_o(neuron_index_o), .busy_o(busy_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tables as written, plus drop counter.
    logic [11:0] m_naddr [10];
    logic        m_sv [16];
    logic [11:0] m_ss [16];
    logic [3:0]  m_sd [16];
    logic [15:0] m_sw [16];
    int          m_drop;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  idx;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_naddr[i] = 12'hFFF;
        for (int e = 0; e < 16; e++) begin
            m_sv[e] = 1'b0; m_ss[e] = '0; m_sd[e] = '0; m_sw[e] = '0;
        end
        m_drop = 0;
    endtask

    // Expected behaviour of one accepted packet: lowest matching neuron,
    // then one strobe per qualifying synapse entry in table order.
    task automatic model_accept(input logic [23:0] p, input int n, input bit timed);
        int k;
        exp_t e;
        k = -1;
        for (int i = 0; i < 10; i++)
            if (k < 0 && m_naddr[i] == p[11:0]) k = i;
        if (k < 0) begin
            if (m_drop < 255) m_drop++;
        end else begin
            for (int s = 0; s < 16; s++) begin
                if (m_sv[s] && m_ss[s] == p[23:12] && int'(m_sd[s]) == k) begin
                    e.w   = m_sw[s];
                    e.idx = 4'(k);
                    e.cyc = timed ? n + 3 + s : -1;
                    sbq.push_back(e);
                end
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && weight_valid_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got weight %0h index %0d, required no strobe (cycle %0d)",
                         weight_out_o, neuron_index_o, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("strobe_weight", 32'(weight_out_o), 32'(mon_e.w));
                chk("strobe_index", 32'(neuron_index_o), 32'(mon_e.idx));
                if (mon_e.cyc >= 0) chk("strobe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic cfg_neuron(input int i, input logic [11:0] a);
        @(negedge clk_i);
        cfg_neuron_we_i = 1'b1; cfg_neuron_idx_i = 4'(i); cfg_neuron_addr_i = a;
        @(negedge clk_i);
        cfg_neuron_we_i = 1'b0;
        m_naddr[i] = a;
    endtask

    task automatic cfg_syn(input int i, input bit v, input logic [11:0] s, input int d, input logic [15:0] w);
        @(negedge clk_i);
        cfg_syn_we_i = 1'b1; cfg_syn_idx_i = 4'(i);
        cfg_syn_entry_i = {v, s, 4'(d), w};
        @(negedge clk_i);
        cfg_syn_we_i = 1'b0;
        m_sv[i] = v; m_ss[i] = s; m_sd[i] = 4'(d); m_sw[i] = w;
    endtask

    // Present a packet; n returns the accepting edge number. keep leaves
    // valid asserted so the next send follows back-to-back.
    task automatic send(input logic [23:0] p, input bit timed, input bit keep, output int n);
        int  tries;
        bit  acc;
        tries = 0; acc = 0; n = -1;
        @(negedge clk_i);
        packet_i = p; packet_valid_i = 1'b1;
        while (!acc) begin
            #1;
            if (packet_ready_o) begin
                @(posedge clk_i);
                #1;
                n = cyc; acc = 1;
                model_accept(p, n, timed);
            end else begin
                tries++;
                if (tries > 200) begin
                    fail_now("send_timeout");
                    packet_valid_i = 1'b0;
                    break;
                end
                @(negedge clk_i);
            end
        end
        if (!keep) begin
            @(negedge clk_i);
            packet_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk_i);
        while (busy_o && t < 400) begin
            @(negedge clk_i);
            t++;
        end
        if (busy_o) fail_now("idle_timeout");
        @(negedge clk_i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, nc;
        int acc_cyc [6];
        exp_t keepq[$];

        rst_i = 1'b1; clear_i = 1'b0; packet_i = '0; packet_valid_i = 1'b0;
        cfg_neuron_we_i = 1'b0; cfg_neuron_idx_i = '0; cfg_neuron_addr_i = '0;
        cfg_syn_we_i = 1'b0; cfg_syn_idx_i = '0; cfg_syn_entry_i = '0;
        model_reset();

        // Reset state
        tick(3);
        chk("rst_ready", 32'(packet_ready_o), 32'd1);
        chk("rst_wvalid", 32'(weight_valid_o), 32'd0);
        chk("rst_weight", 32'(weight_out_o), 32'd0);
        chk("rst_index", 32'(neuron_index_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_drop", 32'(drop_count_o), 32'd0);
        rst_i = 1'b0;
        tick(2);

        // Basic hit: single strobe from entry 5 at N+8
        cfg_neuron(3, 12'h0A5);
        cfg_syn(5, 1'b1, 12'h123, 3, 16'h0040);
        wait_idle();
        send(24'h1230A5, 1'b1, 1'b0, n);
        while (cyc < n + 19) @(negedge clk_i);
        chk("basic_busy_low", 32'(busy_o), 32'd0);
        wait_idle();

        // Multi-hit on entries 0 and 15, then an unmatched destination
        cfg_syn(0, 1'b1, 12'h456, 3, 16'hA001);
        cfg_syn(15, 1'b1, 12'h456, 3, 16'hA00F);
        wait_idle();
        send(24'h4560A5, 1'b1, 1'b0, n);
        wait_idle();
        send(24'h456BBB, 1'b1, 1'b0, n);
        wait_idle();
        chk("drop_after_miss", 32'(drop_count_o), 32'(m_drop));

        // Duplicate neuron addresses: lowest index wins
        cfg_neuron(2, 12'h050);
        cfg_neuron(7, 12'h050);
        cfg_syn(1, 1'b1, 12'h777, 2, 16'h1111);
        cfg_syn(2, 1'b1, 12'h777, 7, 16'h2222);
        wait_idle();
        send(24'h777050, 1'b1, 1'b0, n);
        wait_idle();

        // FIFO full: six back-to-back matching packets
        cfg_neuron(5, 12'h5A5);
        cfg_syn(3, 1'b1, 12'h600, 5, 16'($urandom));
        cfg_syn(9, 1'b1, 12'h601, 5, 16'($urandom));
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            send({(i % 2 == 0) ? 12'h600 : 12'h601, 12'h5A5}, i == 0, i < 5, acc_cyc[i]);
            // The first packet moves to the work register, so the fifth fills the FIFO.
            if (i == 4) chk("ready_low_when_full", 32'(packet_ready_o), 32'd0);
        end
        chk("burst_first5_spacing", acc_cyc[4] - acc_cyc[0], 4);
        chk("ready_reassert_after_pop", acc_cyc[5] - acc_cyc[4], 16);
        wait_idle();

        // clear during SCAN entry 4 with two packets queued
        cfg_neuron(4, 12'h0C4);
        for (int e = 0; e < 16; e++)
            cfg_syn(e, e != 4, 12'hABC, 4, 16'h0100 + 16'(e));
        wait_idle();
        send(24'hABC0C4, 1'b1, 1'b1, n);
        send(24'hABC0C4, 1'b0, 1'b1, nb);
        send(24'hABC0C4, 1'b0, 1'b0, nc);
        while (cyc < n + 6) @(negedge clk_i);
        clear_i = 1'b1;
        #2;
        keepq.delete();
        foreach (sbq[j]) if (sbq[j].cyc >= 0 && sbq[j].cyc < n + 7) keepq.push_back(sbq[j]);
        sbq = keepq;
        @(negedge clk_i);
        clear_i = 1'b0;
        @(negedge clk_i);
        chk("clear_busy", 32'(busy_o), 32'd0);
        chk("clear_ready", 32'(packet_ready_o), 32'd1);
        chk("clear_drop_kept", 32'(drop_count_o), 32'(m_drop));
        tick(25);
        chk("clear_no_pending", sbq.size(), 0);

        // Randomized batches against the model
        for (int b = 0; b < 3; b++) begin
            wait_idle();
            for (int i = 0; i < 10; i++) cfg_neuron(i, 12'h100 + 12'($urandom_range(0, 5)));
            for (int e = 0; e < 16; e++)
                cfg_syn(e, ($urandom % 4) != 0, 12'h200 + 12'($urandom_range(0, 2)),
                        int'($urandom_range(0, 11)), 16'($urandom));
            for (int i = 0; i < 15; i++) begin
                bit kp;
                kp = (i < 14) && ($urandom % 2 == 1);
                send({12'h200 + 12'($urandom_range(0, 3)), 12'h100 + 12'($urandom_range(0, 7))},
                     1'b0, kp, n);
                if (!kp) tick(int'($urandom_range(0, 3)));
            end
            wait_idle();
            chk("random_drop", 32'(drop_count_o), 32'(m_drop));
        end

        // drop_count saturation
        wait_idle();
        for (int i = 0; i < 260; i++) send(24'h999BBB, 1'b0, i < 259, n);
        wait_idle();
        chk("drop_saturated", 32'(drop_count_o), 32'd255);

        // Asynchronous reset mid-scan
        cfg_neuron(0, 12'h3AA);
        cfg_syn(9, 1'b1, 12'h3CC, 0, 16'hBEEF);
        wait_idle();
        send(24'h3CC3AA, 1'b1, 1'b0, n);
        while (cyc < n + 5) @(negedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_ready", 32'(packet_ready_o), 32'd1);
        chk("arst_wvalid", 32'(weight_valid_o), 32'd0);
        chk("arst_weight", 32'(weight_out_o), 32'd0);
        chk("arst_index", 32'(neuron_index_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_drop", 32'(drop_count_o), 32'd0);
        sbq.delete();
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        tick(25);
        // Tables are back to 'never matches', so the same packet now drops.
        send(24'h3CC3AA, 1'b1, 1'b0, n);
        wait_idle();
        chk("post_reset_drop", 32'(drop_count_o), 32'(m_drop));

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
